// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: W-bit words in over valid/ready, one bit per clock out, MSB first.
// A one-word holding buffer lets consecutive words stream with no idle bit between them.
module bit_serializer #(
  parameter int   W        = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] din,
  input  logic         dvld,
  output logic         drdy,
  output logic         o,
  output logic         frm,
  output logic         sof
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } st_t;

  st_t           st_q, st_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hb_q, hb_d;
  logic          hv_q, hv_d;
  logic          accept;

  // An accept needs an empty buffer and a drain needs a full one, so both never collide.
  assign accept = dvld && !hv_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q  <= IDLE;
      sr_q  <= '0;
      cnt_q <= '0;
      hb_q  <= '0;
      hv_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      hb_q  <= hb_d;
      hv_q  <= hv_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    hb_d  = hb_q;
    hv_d  = hv_q;

    if (accept) begin
      hb_d = din;
      hv_d = 1'b1;
    end

    unique case (st_q)
      IDLE: begin
        if (hv_q) begin
          sr_d  = hb_q;
          cnt_d = CNT_LAST;
          hv_d  = 1'b0;
          st_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sr_d  = {sr_q[W-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
        end else if (hv_q) begin
          // Reload straight from the buffer so the next MSB follows the last bit.
          sr_d  = hb_q;
          cnt_d = CNT_LAST;
          hv_d  = 1'b0;
        end else begin
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    drdy = !hv_q;
    frm  = (st_q == SHIFT);
    o    = frm ? sr_q[W-1] : IDLE_BIT;
    sof  = frm && (cnt_q == CNT_LAST);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized scoreboard bench for bit_serializer: accepted words expand into an expected bit stream.
`timescale 1ns/1ps
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [W-1:0] din = '0;
  logic         dvld = 1'b0;
  logic         drdy, o, frm, sof;

  bit_serializer #(.W(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_b(rst_b), .din(din), .dvld(dvld),
    .drdy(drdy), .o(o), .frm(frm), .sof(sof)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic s; } ebit_t;

  ebit_t        exp_q[$];
  logic [W-1:0] held_w;
  logic         held_vld;
  logic         m_acc;
  ebit_t        mon_e;
  logic         mon_ef;
  logic [3:0]   hist;
  int           det_hits = 0;
  int           n_cmp = 0;
  int           n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: a word waits in a one-deep buffer and expands into the bit stream once the stream runs dry.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      exp_q.delete();
      held_vld = 1'b0;
      held_w   = '0;
    end else begin
      m_acc = dvld && !held_vld;
      if (held_vld && exp_q.size() == 0) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back('{b: held_w[i], s: (i == W - 1)});
        held_vld = 1'b0;
      end
      if (m_acc) begin
        held_w   = din;
        held_vld = 1'b1;
      end
    end
  end

  // Monitor: compares the displayed bit each cycle and feeds a 1011 detector model.
  always @(negedge clk) begin
    if (!rst_b) begin
      hist = '0;
    end else begin
      mon_ef = (exp_q.size() > 0);
      chk("drdy", 32'(drdy), 32'(!held_vld));
      chk("frm", 32'(frm), 32'(mon_ef));
      if (mon_ef) begin
        mon_e = exp_q.pop_front();
        chk("o", 32'(o), 32'(mon_e.b));
        chk("sof", 32'(sof), 32'(mon_e.s));
        hist = {hist[2:0], o};
        if (hist == 4'b1011) det_hits++;
      end else begin
        chk("o_idle", 32'(o), 32'd0);
        chk("sof_idle", 32'(sof), 32'd0);
      end
    end
  end

  // Call at a falling edge; leaves dvld low at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] w, input bit tog);
    int t;
    bit acc;
    t = 0;
    acc = 1'b0;
    din  = w;
    dvld = 1'b1;
    while (!acc && t < 300) begin
      acc = !held_vld;
      @(posedge clk);
      t++;
      if (!acc) begin
        @(negedge clk);
        if (tog) din = W'($urandom);
      end
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    dvld = 1'b0;
    din  = W'($urandom);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || held_vld) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int t;

    #2;
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_frm", 32'(frm), 32'd0);
    chk("rst_sof", 32'(sof), 32'd0);
    chk("rst_drdy", 32'(drdy), 32'd1);
    #10 rst_b = 1'b1;
    repeat (6) @(negedge clk);

    h0 = det_hits;
    send(8'hB0, 1'b0);
    wait_drain();
    chk("det_hits_single", 32'(det_hits - h0), 32'd1);

    send(8'hB0, 1'b0);
    send(8'h0B, 1'b0);
    wait_drain();

    send(8'h3C, 1'b0);
    send(8'hA5, 1'b0);
    send(8'h00, 1'b1);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, W + 3)) @(negedge clk);
    end
    wait_drain();

    send(8'hFF, 1'b0);
    send(8'h5A, 1'b0);
    t = 0;
    while (exp_q.size() != 4 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("bit3_reached", 32'(exp_q.size()), 32'd4);
    #1 rst_b = 1'b0;
    #1;
    chk("midrst_o", 32'(o), 32'd0);
    chk("midrst_frm", 32'(frm), 32'd0);
    chk("midrst_sof", 32'(sof), 32'd0);
    chk("midrst_drdy", 32'(drdy), 32'd1);
    @(negedge clk);
    #3 rst_b = 1'b1;
    repeat (12) @(negedge clk);
    send(8'hB0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
